reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- 32x32 general-purpose register file with a per-register busy scoreboard. It sits directly downstream of the 5-bit write-register select mux (rt/rd choice).
- The selected 5-bit address arrives on wa and is written with wd at writeback.
- Two combinational read ports feed the ALU operand path. The scoreboard raises stall when a source register still has an outstanding write.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, register count (2**ADDR_W)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address
- rs_data  output  DATA_W  read port A data (combinational)
- rt_data  output  DATA_W  read port B data (combinational)
- we  input  1  writeback enable
- wa  input  ADDR_W  writeback register address (from 5-bit 2:1 select mux)
- wd  input  DATA_W  writeback data
- issue_valid  input  1  instruction issuing this cycle has a register destination
- issue_wa  input  ADDR_W  destination register of issuing instruction
- stall  output  1  source operand not ready; issue blocked
- busy_cnt  output  ADDR_W+1  number of registers currently marked busy

Behaviour:
- Reset: the single clock is clk. Reset is rst, synchronous and active-high.
- On a clk edge with rst=1, all registers go to 0 and all busy bits clear. busy_cnt=0 and stall=0 from the next cycle.
- rst has priority over we and issue_valid in the same cycle.
- Register 0: always reads 0. Writes to wa=0 are dropped. issue_wa=0 never sets busy.
- Write: on the clk edge when we=1 and wa!=0, reg[wa] <= wd. Write latency is 1 cycle.
- Read: rs_data/rt_data are combinational from rs_addr/rt_addr.
- Bypass: if we=1, wa!=0 and wa==rs_addr, rs_data=wd in the same cycle (write-through). The same rule applies to rt. Both ports may bypass simultaneously.
- Scoreboard set: on the clk edge when issue_valid=1, issue_wa!=0 and stall=0, busy[issue_wa] <= 1.
- Scoreboard clear: on the clk edge when we=1 and wa!=0, busy[wa] <= 0.
- Set and clear of the same register in one cycle: set wins, because the new producer overrides. busy stays 1.
- stall = (busy[rs_addr] && !(we && wa==rs_addr)) || (busy[rt_addr] && !(we && wa==rt_addr)). Address 0 is never busy. stall is purely combinational.
- While stall=1, issue_valid is ignored and no busy bit is set.
- busy_cnt is a registered population count of the busy bits. It is updated in the same edge as the busy vector, so it equals popcount(busy) at all times.
- A writeback to a non-busy register is legal: data is written, busy is unchanged.

Optional Feature:
- Macro: REG_FILE_SB_DEBUG_PORT_EN
- Defined:
  - adds input dbg_addr[ADDR_W-1:0] and output dbg_data[DATA_W-1:0], a third combinational read port with no bypass (shows committed state only);
  - adds output dbg_busy[NUM_REGS-1:0], the raw scoreboard vector.
- Undefined: these ports do not exist. Functional behaviour of all other ports is identical.

Decomposition:
- Shared package reg_file_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS;
  - REG_ZERO (5'd0);
  - typedef reg_addr_t (logic [ADDR_W-1:0]);
  - typedef reg_data_t (logic [DATA_W-1:0]).
- Sub-module rf_scoreboard contains the busy vector, set/clear priority, stall logic and busy_cnt.
- reg_file_sb instantiates rf_scoreboard alongside the storage array and bypass muxes.

Test Plan:
- Reset: rst=1 one cycle after writing reg[3]=0xDEADBEEF and issuing wa=3 -> rs_addr=3 reads 0, stall=0, busy_cnt=0.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF, then issue_valid=1, issue_wa=0 -> rs_addr=0 reads 0, busy_cnt stays 0.
- Bypass: we=1, wa=7, wd=0x12345678, rs_addr=rt_addr=7 in the same cycle -> both outputs are 0x12345678 before the edge, and still 0x12345678 after it via storage.
- Stall/release: issue wa=5 (busy_cnt 0->1); next cycle rs_addr=5 -> stall=1, and issue_valid with issue_wa=9 sets nothing. Then we=1, wa=5 -> stall=0 in that cycle and busy_cnt=0 after the edge.
- Set/clear collision: busy[4]=1; same cycle we=1, wa=4, issue_valid=1, issue_wa=4, with rs/rt not busy -> busy[4] stays 1, busy_cnt unchanged.
- Debug port (macro defined): write reg[10]=0xA5A5A5A5, then in a later cycle we=1, wa=10, wd=0 with dbg_addr=10 -> dbg_data=0xA5A5A5A5 (no bypass), while rs_addr=10 shows 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths, types and helpers for the reg_file_sb register file and its scoreboard.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, clear on writeback, stall on busy sources.
// REG_FILE_SB_DEBUG_PORT_EN exposes the raw busy vector on dbg_busy.
module rf_scoreboard
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_wa,
    output logic              stall,
`ifdef REG_FILE_SB_DEBUG_PORT_EN
    output logic [NUM_REGS-1:0] dbg_busy,
`endif
    output logic [ADDR_W:0]   busy_cnt
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                rs_wait;
    logic                rt_wait;
    logic                issue_fire;

    // Handshake: an issue is accepted on the rising edge where issue_valid=1 and
    // stall=0; stall never depends on issue_valid, and a writeback in the same
    // cycle releases its register immediately.
    always_comb begin
        rs_wait    = busy[rs_addr] && !(we && (wa == rs_addr));
        rt_wait    = busy[rt_addr] && !(we && (wa == rt_addr));
        stall      = rs_wait || rt_wait;
        issue_fire = issue_valid && (issue_wa != REG_ZERO) && !stall;
    end

    // Clear first, then set: a new producer overrides a retiring one.
    always_comb begin
        busy_next = busy;
        if (we && (wa != REG_ZERO)) begin
            busy_next[wa] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issue_wa] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= popcount(busy_next);
        end
    end

`ifdef REG_FILE_SB_DEBUG_PORT_EN
    assign dbg_busy = busy;
`endif

endmodule

// File: rtl/reg_file_sb.sv
// 32x32 register file with write-through bypass on both read ports and a busy scoreboard.
// REG_FILE_SB_DEBUG_PORT_EN adds a committed-state read port (dbg_addr/dbg_data) and dbg_busy.
module reg_file_sb
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_wa,
    output logic              stall,
`ifdef REG_FILE_SB_DEBUG_PORT_EN
    input  logic [ADDR_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data,
    output logic [NUM_REGS-1:0] dbg_busy,
`endif
    output logic [ADDR_W:0]   busy_cnt
);

    reg_data_t regs [NUM_REGS];
    logic      wr_en;

    assign wr_en = we && (wa != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Register 0 is forced to zero here rather than relying on the array contents.
    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        if (rs_addr == REG_ZERO) begin
            rs_data = '0;
        end else if (wr_en && (wa == rs_addr)) begin
            rs_data = wd;
        end
        if (rt_addr == REG_ZERO) begin
            rt_data = '0;
        end else if (wr_en && (wa == rt_addr)) begin
            rt_data = wd;
        end
    end

`ifdef REG_FILE_SB_DEBUG_PORT_EN
    assign dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs[dbg_addr];
`endif

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .we          (we),
        .wa          (wa),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .stall       (stall),
`ifdef REG_FILE_SB_DEBUG_PORT_EN
        .dbg_busy    (dbg_busy),
`endif
        .busy_cnt    (busy_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, debug-port sequence, then randomized run against a reference model.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        issue_valid;
    logic [4:0]  issue_wa;
    logic        stall;
    logic [5:0]  busy_cnt;
`ifdef REG_FILE_SB_DEBUG_PORT_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] dbg_busy;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q[$];

    reg_file_sb dut (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .stall       (stall),
`ifdef REG_FILE_SB_DEBUG_PORT_EN
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .dbg_busy    (dbg_busy),
`endif
        .busy_cnt    (busy_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  iwa;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic        exp_stall;
        logic [5:0]  exp_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    // Reference model state
    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: apply inputs just after the falling edge.
    task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic iv, input logic [4:0] iwa, input logic [4:0] rs,
                         input logic [4:0] rt);
        @(negedge clk);
        rst         = r;
        we          = w;
        wa          = a;
        wd          = d;
        issue_valid = iv;
        issue_wa    = iwa;
        rs_addr     = rs;
        rt_addr     = rt;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; issue_valid = 1'b0; issue_wa = '0;
        rs_addr = '0; rt_addr = '0;
`ifdef REG_FILE_SB_DEBUG_PORT_EN
        dbg_addr = '0;
`endif
        repeat (2) @(posedge clk);

        //          rst we  wa     wd            iv  iwa    rs     rt     exp_rs        exp_rt        stl cnt
        vecs[0]  = '{0, 1, 5'd3, 32'hDEADBEEF, 1, 5'd3, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        0, 6'd0};
        vecs[1]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 5'd1, 32'hDEADBEEF, 32'h0,        1, 6'd1};
        vecs[2]  = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        1, 6'd1};
        vecs[3]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 5'd3, 32'h0,        32'h0,        0, 6'd0};
        vecs[4]  = '{0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        0, 6'd0};
        vecs[5]  = '{0, 0, 5'd0, 32'h0,        1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        0, 6'd0};
        vecs[6]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        0, 6'd0};
        vecs[7]  = '{0, 1, 5'd7, 32'h12345678, 0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 0, 6'd0};
        vecs[8]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 0, 6'd0};
        vecs[9]  = '{0, 0, 5'd0, 32'h0,        1, 5'd5, 5'd0, 5'd0, 32'h0,        32'h0,        0, 6'd0};
        vecs[10] = '{0, 0, 5'd0, 32'h0,        1, 5'd9, 5'd5, 5'd7, 32'h0,        32'h12345678, 1, 6'd1};
        vecs[11] = '{0, 1, 5'd5, 32'h55,       0, 5'd0, 5'd5, 5'd9, 32'h55,       32'h0,        0, 6'd1};
        vecs[12] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd9, 32'h55,       32'h0,        0, 6'd0};
        vecs[13] = '{0, 0, 5'd0, 32'h0,        1, 5'd4, 5'd0, 5'd0, 32'h0,        32'h0,        0, 6'd0};
        vecs[14] = '{0, 1, 5'd4, 32'h44,       1, 5'd4, 5'd7, 5'd5, 32'h12345678, 32'h55,       0, 6'd1};
        vecs[15] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd0, 32'h44,       32'h0,        1, 6'd1};
        vecs[16] = '{0, 1, 5'd4, 32'h40,       0, 5'd0, 5'd4, 5'd0, 32'h40,       32'h0,        0, 6'd1};
        vecs[17] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd0, 32'h40,       32'h0,        0, 6'd0};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iv, vecs[i].iwa,
                  vecs[i].rs, vecs[i].rt);
            #1;
            check($sformatf("vec%0d rs_data", i), rs_data, vecs[i].exp_rs);
            check($sformatf("vec%0d rt_data", i), rt_data, vecs[i].exp_rt);
            check($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].exp_stall});
            check($sformatf("vec%0d busy_cnt", i), {26'b0, busy_cnt}, {26'b0, vecs[i].exp_cnt});
        end

`ifdef REG_FILE_SB_DEBUG_PORT_EN
        // Debug port shows committed state, not the in-flight write.
        drive(0, 1, 5'd10, 32'hA5A5A5A5, 0, 5'd0, 5'd0, 5'd0);
        drive(0, 1, 5'd10, 32'h0, 0, 5'd0, 5'd10, 5'd0);
        dbg_addr = 5'd10;
        #1;
        check("dbg_data no bypass", dbg_data, 32'hA5A5A5A5);
        check("dbg rs bypass", rs_data, 32'h0);
        drive(0, 0, 5'd0, 32'h0, 1, 5'd6, 5'd0, 5'd0);
        @(posedge clk); #1;
        check("dbg_busy", dbg_busy, 32'h0000_0040);
        drive(0, 1, 5'd6, 32'h6, 0, 5'd0, 5'd0, 5'd0);
`endif

        // Randomized phase against the reference model.
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        for (int n = 0; n < 400; n++) begin
            logic        r, w, iv, e_stall;
            logic [4:0]  a, iwa, rs, rt;
            logic [31:0] d, e_rs, e_rt;
            r   = ($urandom_range(0, 60) == 0);
            w   = ($urandom_range(0, 2) != 0);
            a   = 5'($urandom_range(0, 7));
            d   = $urandom;
            iv  = ($urandom_range(0, 1) == 1);
            iwa = 5'($urandom_range(0, 7));
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            drive(r, w, a, d, iv, iwa, rs, rt);
`ifdef REG_FILE_SB_DEBUG_PORT_EN
            dbg_addr = 5'($urandom_range(0, 7));
`endif
            e_rs = (rs == 0) ? 32'h0 : ((w && a == rs) ? d : m_reg[rs]);
            e_rt = (rt == 0) ? 32'h0 : ((w && a == rt) ? d : m_reg[rt]);
            exp_q.push_back(e_rs);
            exp_q.push_back(e_rt);
            e_stall = (m_busy[rs] && !(w && a == rs)) || (m_busy[rt] && !(w && a == rt));
            #1;
            check("rand rs_data", rs_data, exp_q.pop_front());
            check("rand rt_data", rt_data, exp_q.pop_front());
            check("rand stall", {31'b0, stall}, {31'b0, e_stall});
            check("rand busy_cnt", {26'b0, busy_cnt}, 32'(model_count()));
`ifdef REG_FILE_SB_DEBUG_PORT_EN
            check("rand dbg_data", dbg_data, m_reg[dbg_addr]);
`endif
            if (r) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[i]  = 32'h0;
                    m_busy[i] = 1'b0;
                end
            end else begin
                if (w && a != 0) begin
                    m_reg[a]  = d;
                    m_busy[a] = 1'b0;
                end
                if (iv && iwa != 0 && !e_stall) m_busy[iwa] = 1'b1;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
